// File: rtl/moore_fsm_ol.sv
// moore_fsm_ol: Moore-type serial detector for the bit pattern 1-1-0-1-1, with
// overlapping matches allowed. One input bit is sampled per rising clock edge.
// The detect flag is decoded only from the state register, so there is no
// combinational path from the serial input to the flag.
//
// Build option: define MOORE_FSM_OL_DBG_EN to add the debug outputs state_o
// (mirror of the state register) and det_cnt (number of detections since
// reset, wrapping modulo 2^CNT_W). The clk/rst/in/out behaviour is the same in
// both builds; CNT_W has no effect when the debug build is off.
module moore_fsm_ol #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,      // synchronous, active-low
  input  logic             in,
`ifdef MOORE_FSM_OL_DBG_EN
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] det_cnt,
`endif
  output logic             out
);

  // Each state is the longest suffix of the input that is also a prefix of
  // the pattern. Codes 6 and 7 are unreachable and recover to S0.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // nothing matched
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "110"
    S4 = 3'd4,  // "1101"
    S5 = 3'd5   // "11011" - full match
  } state_t;

  state_t r_state;
  state_t w_next;

  // State register; reset discards any partial match.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; S5 falls back to its overlapping suffix.
  always_comb begin
    w_next = S0;
    case (r_state)
      S0:      w_next = in ? S1 : S0;
      S1:      w_next = in ? S2 : S0;
      S2:      w_next = in ? S2 : S3;  // a run of 1s still leaves "11"
      S3:      w_next = in ? S4 : S0;
      S4:      w_next = in ? S5 : S0;
      S5:      w_next = in ? S2 : S3;  // "110111" keeps "11", "110110" keeps "110"
      default: w_next = S0;            // unused codes 6 and 7
    endcase
  end

  // Moore output: high for the whole cycle spent in S5.
  always_comb begin
    out = (r_state == S5);
  end

`ifdef MOORE_FSM_OL_DBG_EN
  logic [CNT_W-1:0] r_det_cnt;

  // Count every edge that enters S5; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_det_cnt <= '0;
    end else if (w_next == S5) begin
      r_det_cnt <= r_det_cnt + 1'b1;
    end
  end

  // Expose the raw state register and the counter.
  always_comb begin
    state_o = r_state;
    det_cnt = r_det_cnt;
  end
`endif

endmodule

// File: tb/tb_moore_fsm_ol.sv
// tb_moore_fsm_ol: scoreboard bench for moore_fsm_ol. A driver applies one
// bit (or reset) per cycle and pushes the expected response computed from
// the input history; a monitor pops and compares after every rising edge.
module tb_moore_fsm_ol;

  localparam int CNT_W = 8;
  localparam int EW    = 1 + CNT_W + 3;   // {state, count, out}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in  = 1'b0;
  logic out;
`ifdef MOORE_FSM_OL_DBG_EN
  logic [2:0]       state_o;
  logic [CNT_W-1:0] det_cnt;
`endif

  always #5 clk = ~clk;

  moore_fsm_ol #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
`ifdef MOORE_FSM_OL_DBG_EN
    .state_o (state_o),
    .det_cnt (det_cnt),
`endif
    .out     (out)
  );

  // ---------------- reference model ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int  hist[$];              // last (up to) 5 bits seen since reset
  int  m_cnt       = 0;      // detections since reset
  int  exp_pulses  = 0;
  int  obs_pulses  = 0;
  int  pat[5]      = '{1, 1, 0, 1, 1};

  // Length of the longest suffix of the history that starts the pattern.
  function automatic int match_len();
    for (int len = 5; len > 0; len--) begin
      if (hist.size() >= len) begin
        bit ok = 1'b1;
        for (int j = 0; j < len; j++) begin
          if (hist[hist.size() - len + j] != pat[j]) ok = 1'b0;
        end
        if (ok) return len;
      end
    end
    return 0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit r_n, input bit b);
    int  st;
    bit  o;
    @(negedge clk);
    rst = r_n;
    in  = b;
    if (!r_n) begin
      hist.delete();
      m_cnt = 0;
    end else begin
      hist.push_back(b);
      if (hist.size() > 5) void'(hist.pop_front());
    end
    st = match_len();
    o  = (st == 5);
    if (o) begin
      m_cnt++;
      exp_pulses++;
    end
    exp_q.push_back({3'(st), CNT_W'(m_cnt), o});
  endtask

  task automatic drive_bits(input int n, input logic [31:0] bits);
    // bits[n-1] is sent first
    for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i]);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (out !== e[0]) begin
        failures++;
        $display("FAIL out: got %b expected %b at %0t", out, e[0], $time);
      end
      if (out === 1'b1) obs_pulses++;
`ifdef MOORE_FSM_OL_DBG_EN
      checks++;
      if (det_cnt !== e[CNT_W:1]) begin
        failures++;
        $display("FAIL det_cnt: got %0d expected %0d at %0t", det_cnt, e[CNT_W:1], $time);
      end
      checks++;
      if (state_o !== e[EW-1 -: 3]) begin
        failures++;
        $display("FAIL state_o: got %0d expected %0d at %0t", state_o, e[EW-1 -: 3], $time);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset held two edges with in=1
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    // single match, then in=0 -> S3
    drive_bits(6, 32'b110110);
    // overlapping back-to-back matches
    drive(1'b0, 1'b0);
    drive_bits(8, 32'b11011011);
    // leading extra 1 absorbed, then constant-1 stream
    drive(1'b0, 1'b0);
    drive_bits(6, 32'b111011);
    drive(1'b0, 1'b0);
    drive_bits(12, 32'hFFF);
    // reset mid-sequence discards history
    drive(1'b0, 1'b0);
    drive_bits(4, 32'b1101);
    drive(1'b0, 1'b1);
    drive_bits(2, 32'b11);
    // random stream with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) drive(1'b0, 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0);
      else drive(1'b1, 1'($urandom_range(0, 1)));
    end
    // 260 detections to wrap the counter
    drive(1'b0, 1'b0);
    drive_bits(5, 32'b11011);
    for (int i = 0; i < 259; i++) drive_bits(3, 32'b011);
    drive(1'b1, 1'b0);
    // drain: bounded wait for the monitor to empty the queue
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    checks++;
    if (obs_pulses != exp_pulses) begin
      failures++;
      $display("FAIL pulse_count: got %0d expected %0d", obs_pulses, exp_pulses);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
